batch_dispatcher: RTL
=====================

BATCH_DISPATCHER -- requirements
Module: batch_dispatcher

Interface
REQ-001 Parameter MAX_DEPENDENCIES, default 256, sets the width of each read and write dependency vector.
REQ-002 Parameter MAX_BATCH_SIZE, default 8, sets the number of transaction buffer entries.
REQ-003 Parameter NUM_WORKERS, default 4, sets the number of execution workers; WID = max(1, clog2(NUM_WORKERS)).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 s_axis_tvalid / s_axis_tready  in / out  1 / 1  scheduler-output transaction handshake.
REQ-007 s_axis_tdata_owner_programID  in  64  transaction owner.
REQ-008 s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies  in  MAX_DEPENDENCIES each  dependency vectors.
REQ-009 batch_completed  in  1  single-cycle pulse closing the current batch.
REQ-010 m_axis_tvalid / m_axis_tready  out / in  1 / 1  issue handshake toward workers.
REQ-011 m_axis_tdata_owner_programID (64), m_axis_tdata_read_dependencies and m_axis_tdata_write_dependencies (MAX_DEPENDENCIES each)  out  issued transaction.
REQ-012 m_axis_tdest  out  WID  target worker index.
REQ-013 worker_done_valid / worker_done_id  in  1 / WID  worker completion report.
REQ-014 batch_done  out  1  one-cycle pulse when a batch fully retires.
REQ-015 inflight_mask  out  NUM_WORKERS  busy workers; batches_retired, transactions_issued, spurious_done_count  out  32 each.

Function
REQ-016 State machine: COLLECT, DISPATCH, DRAIN; reset state COLLECT.
REQ-017 COLLECT: s_axis_tready = (count < MAX_BATCH_SIZE); on handshake, write entry at index count and increment count.
REQ-018 COLLECT -> DISPATCH next cycle when batch_completed = 1 and (count > 0 or an accept occurs the same cycle), or when count reaches MAX_BATCH_SIZE.
REQ-019 batch_completed with count = 0 and no same-cycle accept is ignored; batch_completed outside COLLECT is ignored.
REQ-020 s_axis_tready = 0 in DISPATCH and DRAIN.
REQ-021 DISPATCH: m_axis_tvalid = 1 when rd_ptr < count and at least one worker has inflight_mask bit = 0.
REQ-022 m_axis_tdest = lowest-index free worker, latched on the cycle m_axis_tvalid rises.
REQ-023 tdest and all tdata are held stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-024 tdata = buffer[rd_ptr].
REQ-025 Issue handshake: set inflight_mask[tdest], increment rd_ptr, increment transactions_issued.
REQ-026 Zero-cycle bubble between back-to-back issues when a further worker is free.
REQ-027 Latency: trigger in cycle N gives m_axis_tvalid = 1 earliest in cycle N+1.
REQ-028 DISPATCH -> DRAIN on the handshake that makes rd_ptr = count.
REQ-029 worker_done_valid clears inflight_mask[worker_done_id] in any state.
REQ-030 A done for a worker whose inflight bit is 0, or with worker_done_id >= NUM_WORKERS, changes no state and increments spurious_done_count.
REQ-031 Same-cycle done and issue: the done takes effect; free-worker selection uses the registered mask, so a worker freed this cycle is selectable next cycle.
REQ-032 DRAIN: when inflight_mask = 0, pulse batch_done for one cycle, increment batches_retired, clear count and rd_ptr, return to COLLECT.
REQ-033 In DRAIN a done that clears the last inflight bit causes the batch_done pulse on the following cycle.
REQ-034 All 32-bit counters wrap modulo 2^32.

Reset
REQ-035 While rst_n = 0 at a clock edge, every output and internal state goes to zero: state COLLECT, count, rd_ptr, inflight_mask, m_axis_tvalid, batch_done and all counters.
REQ-036 s_axis_tready = 1 on the first cycle after reset release.
REQ-037 Reset mid-batch discards buffered and in-flight transactions without emitting batch_done.
REQ-038 Buffer contents need no reset.

Verification
REQ-039 Accept 3 transactions (IDs 0x10, 0x11, 0x12), pulse batch_completed, m_axis_tready = 1, workers idle -> IDs 0x10, 0x11, 0x12 issued to tdest 0, 1, 2; then done for 0, 1, 2 -> one batch_done, batches_retired = 1.
REQ-040 Send 8 transactions with no batch_completed -> s_axis_tready falls after the 8th; dispatch starts next cycle.
REQ-041 NUM_WORKERS = 4, batch of 6, no done -> 4 issues, then tvalid = 0; done for worker 2 -> 5th issue goes to tdest 2.
REQ-042 Hold m_axis_tready = 0 for 5 cycles while a done for worker 0 arrives -> tdest and tdata stay unchanged until the handshake.
REQ-043 Done for an idle worker, and batch_completed with an empty buffer -> spurious_done_count = 1, no state change, no dispatch.
REQ-044 Assert rst_n = 0 in DRAIN with 2 workers busy -> next cycle inflight_mask = 0, state COLLECT, no batch_done.

Source files
------------

// File: rtl/batch_dispatcher.sv
// batch_dispatcher
//
// Purpose:
//   Collects scheduler-output transactions into a small batch buffer. When a
//   batch is closed, either by batch_completed or by the buffer filling up, it
//   issues the buffered transactions in order to free execution workers. It
//   then waits for every issued worker to report done before it pulses
//   batch_done and starts collecting the next batch.
//
// Ports:
//   clk, rst_n                          single rising-edge clock, synchronous active-low reset
//   s_axis_tvalid / s_axis_tready       incoming transaction handshake
//   s_axis_tdata_owner_programID        incoming transaction owner (64 bits)
//   s_axis_tdata_read_dependencies      incoming read dependency vector
//   s_axis_tdata_write_dependencies     incoming write dependency vector
//   batch_completed                     single-cycle pulse that closes the current batch
//   m_axis_tvalid / m_axis_tready       issue handshake toward the workers
//   m_axis_tdata_*                      issued transaction (owner, read deps, write deps)
//   m_axis_tdest                        index of the target worker
//   worker_done_valid / worker_done_id  worker completion report
//   batch_done                          one-cycle pulse when a batch fully retires
//   inflight_mask                       one bit per busy worker
//   batches_retired                     wrapping count of retired batches
//   transactions_issued                 wrapping count of issue handshakes
//   spurious_done_count                 wrapping count of ignored done reports

module batch_dispatcher #(
    parameter int  MAX_DEPENDENCIES = 256,
    parameter int  MAX_BATCH_SIZE   = 8,
    parameter int  NUM_WORKERS      = 4,
    localparam int WID              = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [63:0]                 s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
    input  logic                        batch_completed,

    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [63:0]                 m_axis_tdata_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
    output logic [WID-1:0]              m_axis_tdest,

    input  logic                        worker_done_valid,
    input  logic [WID-1:0]              worker_done_id,

    output logic                        batch_done,
    output logic [NUM_WORKERS-1:0]      inflight_mask,
    output logic [31:0]                 batches_retired,
    output logic [31:0]                 transactions_issued,
    output logic [31:0]                 spurious_done_count
);

    // count and rd_ptr must be able to hold MAX_BATCH_SIZE itself, so they
    // are one bit wider than the buffer index when the size is a power of two.
    localparam int CW = $clog2(MAX_BATCH_SIZE + 1);
    localparam int IW = (MAX_BATCH_SIZE > 1) ? $clog2(MAX_BATCH_SIZE) : 1;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_n;
    logic [CW-1:0]           rd_ptr;
    logic [CW-1:0]           rd_ptr_n;
    logic [NUM_WORKERS-1:0]  mask_n;
    logic [NUM_WORKERS-1:0]  done_clr;
    logic [NUM_WORKERS-1:0]  issue_set;
    logic [WID-1:0]          free_idx;
    logic [WID-1:0]          dest_n;
    logic                    valid_n;
    logic                    done_ok;
    logic                    retire;
    logic                    accept;
    logic                    issue_fire;

    logic [63:0]                 buffer_owner [MAX_BATCH_SIZE];
    logic [MAX_DEPENDENCIES-1:0] buffer_rd    [MAX_BATCH_SIZE];
    logic [MAX_DEPENDENCIES-1:0] buffer_wr    [MAX_BATCH_SIZE];

    assign s_axis_tready = (state == COLLECT) && (count < CW'(MAX_BATCH_SIZE));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign issue_fire    = m_axis_tvalid && m_axis_tready;

    // rd_ptr only moves on a handshake, so the presented entry stays stable
    // for as long as the worker side stalls.
    assign m_axis_tdata_owner_programID    = buffer_owner[rd_ptr[IW-1:0]];
    assign m_axis_tdata_read_dependencies  = buffer_rd[rd_ptr[IW-1:0]];
    assign m_axis_tdata_write_dependencies = buffer_wr[rd_ptr[IW-1:0]];

    // Buffer storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer_owner[count[IW-1:0]] <= s_axis_tdata_owner_programID;
            buffer_rd[count[IW-1:0]]    <= s_axis_tdata_read_dependencies;
            buffer_wr[count[IW-1:0]]    <= s_axis_tdata_write_dependencies;
        end
    end

    // Next-state computation. The issue outputs are registered, so they are
    // derived from the next-cycle view of state, pointers and busy mask; that
    // gives one cycle from trigger to tvalid and no bubble between issues.
    always_comb begin
        done_clr  = '0;
        done_ok   = 1'b0;
        issue_set = '0;
        retire    = 1'b0;
        state_n   = state;
        count_n   = count;
        rd_ptr_n  = rd_ptr;
        free_idx  = '0;
        valid_n   = 1'b0;
        dest_n    = m_axis_tdest;

        // Only a done for a worker that is actually busy has any effect.
        if (worker_done_valid && (int'(worker_done_id) < NUM_WORKERS)) begin
            if (inflight_mask[worker_done_id]) begin
                done_ok                  = 1'b1;
                done_clr[worker_done_id] = 1'b1;
            end
        end

        // The issued worker was free in the registered mask, so a same-cycle
        // valid done can never target it; set and clear never collide.
        if (issue_fire) begin
            issue_set[m_axis_tdest] = 1'b1;
            rd_ptr_n                = rd_ptr + CW'(1);
        end
        mask_n = (inflight_mask & ~done_clr) | issue_set;

        if (accept) begin
            count_n = count + CW'(1);
        end

        case (state)
            COLLECT: begin
                if ((batch_completed && ((count != '0) || accept)) ||
                    (accept && (count_n == CW'(MAX_BATCH_SIZE)))) begin
                    state_n = DISPATCH;
                end
            end
            DISPATCH: begin
                if (issue_fire && (rd_ptr_n == count)) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (mask_n == '0) begin
                    retire   = 1'b1;
                    state_n  = COLLECT;
                    count_n  = '0;
                    rd_ptr_n = '0;
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase

        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (!mask_n[i]) begin
                free_idx = WID'(i);
            end
        end

        // A stalled offer keeps its destination even if a lower worker frees up.
        if (m_axis_tvalid && !m_axis_tready) begin
            valid_n = 1'b1;
        end else begin
            valid_n = (state_n == DISPATCH) && (rd_ptr_n < count_n) && (mask_n != '1);
            dest_n  = free_idx;
        end
    end

    // State machine and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= COLLECT;
            count               <= '0;
            rd_ptr              <= '0;
            inflight_mask       <= '0;
            m_axis_tvalid       <= 1'b0;
            m_axis_tdest        <= '0;
            batch_done          <= 1'b0;
            batches_retired     <= '0;
            transactions_issued <= '0;
            spurious_done_count <= '0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            rd_ptr        <= rd_ptr_n;
            inflight_mask <= mask_n;
            m_axis_tvalid <= valid_n;
            m_axis_tdest  <= dest_n;
            batch_done    <= retire;
            if (retire) begin
                batches_retired <= batches_retired + 32'd1;
            end
            if (issue_fire) begin
                transactions_issued <= transactions_issued + 32'd1;
            end
            if (worker_done_valid && !done_ok) begin
                spurious_done_count <= spurious_done_count + 32'd1;
            end
        end
    end

endmodule
